// File: rtl/i2c_sda_datapath.sv
// Bit-level SDA datapath for the I2C master: serialises address/TX bytes onto
// SDA, deserialises SDA into RX bytes, and owns the TX pop / RX push strobes.
module i2c_sda_datapath #(
    parameter int ADDR_W = 7
) (
    input  logic              i2c_core_clk_i,
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] slave_addr_i,
    input  logic              rw_i,
    input  logic              sda_low_en_i,
    input  logic              write_addr_en_i,
    input  logic              write_data_en_i,
    input  logic              receive_data_en_i,
    input  logic [2:0]        count_bit_i,
    input  logic              i2c_sda_en_i,
    input  logic              i2c_scl_i,
    input  logic              i2c_sda_i,
    input  logic [7:0]        tx_data_i,
    input  logic              tx_empty_i,
    output logic              tx_rd_en_o,
    input  logic              rx_full_i,
    output logic [7:0]        rx_data_o,
    output logic              rx_wr_en_o,
    output logic              i2c_sda_o,
    output logic              tx_underrun_o,
    output logic              rx_overflow_o
);

    logic       scl_q, scl_d;
    logic       wa_q, wa_d;
    logic       wd_q, wd_d;
    logic [7:0] addr_sr_q, addr_sr_d;
    logic [7:0] tx_sr_q, tx_sr_d;
    logic [7:0] rx_sr_q, rx_sr_d;
    logic       byte_done_q, byte_done_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_wr_en_q, rx_wr_en_d;
    logic       tx_rd_en_q, tx_rd_en_d;
    logic       sda_q, sda_d;
    logic       tx_underrun_q, tx_underrun_d;
    logic       rx_overflow_q, rx_overflow_d;

    logic scl_rise, wa_rise, wd_rise;

    always_comb begin
        scl_rise      = i2c_scl_i & ~scl_q;
        wa_rise       = write_addr_en_i & ~wa_q;
        wd_rise       = write_data_en_i & ~wd_q;
        scl_d         = i2c_scl_i;
        wa_d          = write_addr_en_i;
        wd_d          = write_data_en_i;
        addr_sr_d     = addr_sr_q;
        tx_sr_d       = tx_sr_q;
        rx_sr_d       = rx_sr_q;
        byte_done_d   = 1'b0;
        rx_data_d     = rx_data_q;
        rx_wr_en_d    = 1'b0;
        tx_rd_en_d    = 1'b0;
        tx_underrun_d = tx_underrun_q;
        rx_overflow_d = rx_overflow_q;

        if (wa_rise) begin
            addr_sr_d = {slave_addr_i, rw_i};
        end

        if (wd_rise) begin
            if (!tx_empty_i) begin
                tx_sr_d    = tx_data_i;
                tx_rd_en_d = 1'b1;
            end else begin
                tx_sr_d       = 8'hFF;
                tx_underrun_d = 1'b1;
            end
        end

        if (receive_data_en_i && scl_rise) begin
            rx_sr_d[count_bit_i] = i2c_sda_i;
            byte_done_d          = (count_bit_i == 3'd0);
        end

        if (byte_done_q) begin
            if (!rx_full_i) begin
                rx_data_d  = rx_sr_q;
                rx_wr_en_d = 1'b1;
            end else begin
                rx_overflow_d = 1'b1;
            end
        end

        // Use the freshly loaded byte so bit 7 is correct on the phase's first cycle
        if (sda_low_en_i) begin
            sda_d = 1'b0;
        end else if (!i2c_sda_en_i) begin
            sda_d = 1'b1;
        end else if (write_addr_en_i) begin
            sda_d = addr_sr_d[count_bit_i];
        end else if (write_data_en_i) begin
            sda_d = tx_sr_d[count_bit_i];
        end else begin
            sda_d = 1'b1;
        end
    end

    always_ff @(posedge i2c_core_clk_i) begin
        if (reset_i) begin
            scl_q         <= 1'b1;
            wa_q          <= 1'b0;
            wd_q          <= 1'b0;
            addr_sr_q     <= 8'h00;
            tx_sr_q       <= 8'h00;
            rx_sr_q       <= 8'h00;
            byte_done_q   <= 1'b0;
            rx_data_q     <= 8'h00;
            rx_wr_en_q    <= 1'b0;
            tx_rd_en_q    <= 1'b0;
            sda_q         <= 1'b1;
            tx_underrun_q <= 1'b0;
            rx_overflow_q <= 1'b0;
        end else begin
            scl_q         <= scl_d;
            wa_q          <= wa_d;
            wd_q          <= wd_d;
            addr_sr_q     <= addr_sr_d;
            tx_sr_q       <= tx_sr_d;
            rx_sr_q       <= rx_sr_d;
            byte_done_q   <= byte_done_d;
            rx_data_q     <= rx_data_d;
            rx_wr_en_q    <= rx_wr_en_d;
            tx_rd_en_q    <= tx_rd_en_d;
            sda_q         <= sda_d;
            tx_underrun_q <= tx_underrun_d;
            rx_overflow_q <= rx_overflow_d;
        end
    end

    assign tx_rd_en_o    = tx_rd_en_q;
    assign rx_data_o     = rx_data_q;
    assign rx_wr_en_o    = rx_wr_en_q;
    assign i2c_sda_o     = sda_q;
    assign tx_underrun_o = tx_underrun_q;
    assign rx_overflow_o = rx_overflow_q;

endmodule

// File: tb/tb_i2c_sda_datapath.sv
// Self-checking bench for i2c_sda_datapath: SDA priority table, directed
// multi-cycle sequences, and randomized transactions against a byte-level model.
module tb_i2c_sda_datapath;

    logic       clk = 1'b0;
    logic       reset_i;
    logic [6:0] slave_addr_i;
    logic       rw_i;
    logic       sda_low_en_i;
    logic       write_addr_en_i;
    logic       write_data_en_i;
    logic       receive_data_en_i;
    logic [2:0] count_bit_i;
    logic       i2c_sda_en_i;
    logic       i2c_scl_i;
    logic       i2c_sda_i;
    logic [7:0] tx_data_i;
    logic       tx_empty_i;
    logic       tx_rd_en_o;
    logic       rx_full_i;
    logic [7:0] rx_data_o;
    logic       rx_wr_en_o;
    logic       i2c_sda_o;
    logic       tx_underrun_o;
    logic       rx_overflow_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    i2c_sda_datapath #(.ADDR_W(7)) dut (
        .i2c_core_clk_i    (clk),
        .reset_i           (reset_i),
        .slave_addr_i      (slave_addr_i),
        .rw_i              (rw_i),
        .sda_low_en_i      (sda_low_en_i),
        .write_addr_en_i   (write_addr_en_i),
        .write_data_en_i   (write_data_en_i),
        .receive_data_en_i (receive_data_en_i),
        .count_bit_i       (count_bit_i),
        .i2c_sda_en_i      (i2c_sda_en_i),
        .i2c_scl_i         (i2c_scl_i),
        .i2c_sda_i         (i2c_sda_i),
        .tx_data_i         (tx_data_i),
        .tx_empty_i        (tx_empty_i),
        .tx_rd_en_o        (tx_rd_en_o),
        .rx_full_i         (rx_full_i),
        .rx_data_o         (rx_data_o),
        .rx_wr_en_o        (rx_wr_en_o),
        .i2c_sda_o         (i2c_sda_o),
        .tx_underrun_o     (tx_underrun_o),
        .rx_overflow_o     (rx_overflow_o)
    );

    typedef struct {
        logic       low;
        logic       en;
        logic       wa;
        logic       wd;
        logic [2:0] cnt;
        logic       exp_sda;
    } vec_t;

    vec_t vecs[14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        sda_low_en_i      = 1'b0;
        write_addr_en_i   = 1'b0;
        write_data_en_i   = 1'b0;
        receive_data_en_i = 1'b0;
        i2c_sda_en_i      = 1'b1;
        i2c_scl_i         = 1'b0;
        i2c_sda_i         = 1'b1;
        rx_full_i         = 1'b0;
        tx_empty_i        = 1'b0;
        count_bit_i       = 3'd7;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " sda"}, i2c_sda_o, 1'b1);
        check({tag, " tx_rd_en"}, tx_rd_en_o, 1'b0);
        check({tag, " rx_wr_en"}, rx_wr_en_o, 1'b0);
        check({tag, " rx_data"}, rx_data_o, 8'h00);
        check({tag, " underrun"}, tx_underrun_o, 1'b0);
        check({tag, " overflow"}, rx_overflow_o, 1'b0);
    endtask

    // Receive one byte MSB first over 8 SCL pulses; checks push timing.
    task automatic do_read(input logic [7:0] b, input logic full,
                           input logic [7:0] exp_data);
        int pushes;
        pushes = 0;
        rx_full_i = full;
        receive_data_en_i = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            count_bit_i = 3'(i);
            i2c_sda_i = b[i];
            i2c_scl_i = 1'b0;
            step();
            pushes += int'(rx_wr_en_o);
            i2c_scl_i = 1'b1;
            step();
            pushes += int'(rx_wr_en_o);
            check("read sda released", i2c_sda_o, 1'b1);
        end
        check("read no early push", pushes, 0);
        i2c_scl_i = 1'b0;
        step();
        check("read push strobe", rx_wr_en_o, !full);
        check("read rx_data", rx_data_o, exp_data);
        step();
        check("read push one cycle", rx_wr_en_o, 1'b0);
        receive_data_en_i = 1'b0;
        rx_full_i = 1'b0;
    endtask

    logic [7:0] abyte, dbyte, rbyte, nxt;
    logic       emp, full;
    logic       exp_under, exp_over;
    logic [7:0] exp_rx;
    int         pops;

    initial begin
        idle_inputs();
        reset_i      = 1'b1;
        slave_addr_i = 7'h50;
        rw_i         = 1'b0;
        tx_data_i    = 8'hA5;
        step();
        step();
        check_reset_state("reset");
        reset_i = 1'b0;
        step();

        // Address byte is 0xA0, TX byte 0xA5
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd7, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd7, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd6, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd7, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd6, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1};
        for (int i = 0; i < 14; i++) begin
            sda_low_en_i    = vecs[i].low;
            i2c_sda_en_i    = vecs[i].en;
            write_addr_en_i = vecs[i].wa;
            write_data_en_i = vecs[i].wd;
            count_bit_i     = vecs[i].cnt;
            step();
            check($sformatf("table[%0d] sda", i), i2c_sda_o, vecs[i].exp_sda);
        end
        idle_inputs();
        step();

        // Address write 0x50/W over bits 7..0
        abyte = 8'hA0;
        write_addr_en_i = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            count_bit_i = 3'(i);
            step();
            check($sformatf("addr bit%0d", i), i2c_sda_o, abyte[i]);
        end
        idle_inputs();
        step();

        // Data write 0xA5: one pop, FIFO head changes after pop
        pops = 0;
        tx_data_i = 8'hA5;
        write_data_en_i = 1'b1;
        dbyte = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            count_bit_i = 3'(i);
            step();
            pops += int'(tx_rd_en_o);
            if (i == 7) check("data pop first cycle", tx_rd_en_o, 1'b1);
            tx_data_i = 8'h3E;
            check($sformatf("data bit%0d", i), i2c_sda_o, dbyte[i]);
        end
        check("data single pop", pops, 1);
        check("data no underrun", tx_underrun_o, 1'b0);
        idle_inputs();
        step();

        // Underrun
        pops = 0;
        tx_empty_i = 1'b1;
        write_data_en_i = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            count_bit_i = 3'(i);
            step();
            pops += int'(tx_rd_en_o);
            check($sformatf("underrun bit%0d", i), i2c_sda_o, 1'b1);
        end
        check("underrun no pop", pops, 0);
        check("underrun flag", tx_underrun_o, 1'b1);
        idle_inputs();
        step();
        step();
        check("underrun sticky", tx_underrun_o, 1'b1);

        // Read 0x3C, then overflow read, then sda_low during data phase
        do_read(8'h3C, 1'b0, 8'h3C);
        check("read no overflow", rx_overflow_o, 1'b0);
        do_read(8'h5A, 1'b1, 8'h3C);
        check("overflow flag", rx_overflow_o, 1'b1);
        write_data_en_i = 1'b1;
        tx_data_i = 8'hFF;
        step();
        sda_low_en_i = 1'b1;
        step();
        check("sda_low over data", i2c_sda_o, 1'b0);
        idle_inputs();
        step();

        // Abort mid-byte with reset, then a clean 0xFF byte
        receive_data_en_i = 1'b1;
        for (int i = 7; i >= 4; i--) begin
            count_bit_i = 3'(i);
            i2c_sda_i = 1'b0;
            i2c_scl_i = 1'b0;
            step();
            i2c_scl_i = 1'b1;
            step();
        end
        reset_i = 1'b1;
        step();
        check_reset_state("midreset");
        reset_i = 1'b0;
        idle_inputs();
        step();
        do_read(8'hFF, 1'b0, 8'hFF);

        // Randomized transactions against a byte-level model
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        exp_under = 1'b0;
        exp_over  = 1'b0;
        exp_rx    = 8'h00;
        for (int t = 0; t < 40; t++) begin
            idle_inputs();
            step();
            case ($urandom_range(0, 2))
                0: begin
                    slave_addr_i = 7'($urandom);
                    rw_i = 1'($urandom);
                    abyte = {slave_addr_i, rw_i};
                    write_addr_en_i = 1'b1;
                    for (int i = 7; i >= 0; i--) begin
                        count_bit_i = 3'(i);
                        step();
                        check("rnd addr bit", i2c_sda_o, (abyte >> i) & 8'd1);
                    end
                end
                1: begin
                    dbyte = 8'($urandom);
                    emp = ($urandom_range(0, 3) == 0);
                    tx_data_i = dbyte;
                    tx_empty_i = emp;
                    write_data_en_i = 1'b1;
                    pops = 0;
                    for (int i = 7; i >= 0; i--) begin
                        count_bit_i = 3'(i);
                        step();
                        pops += int'(tx_rd_en_o);
                        nxt = 8'($urandom);
                        tx_data_i = nxt;
                        check("rnd data bit", i2c_sda_o,
                              emp ? 1 : ((dbyte >> i) & 8'd1));
                    end
                    exp_under = exp_under | emp;
                    check("rnd pops", pops, emp ? 0 : 1);
                end
                default: begin
                    rbyte = 8'($urandom);
                    full = ($urandom_range(0, 3) == 0);
                    if (!full) exp_rx = rbyte;
                    exp_over = exp_over | full;
                    do_read(rbyte, full, exp_rx);
                end
            endcase
            check("rnd underrun", tx_underrun_o, exp_under);
            check("rnd overflow", rx_overflow_o, exp_over);
            check("rnd rx_data", rx_data_o, exp_rx);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
